// File: rtl/alu_pkg.sv
// alu_pkg: opcode map shared between the ALU sharing controller and the ALU,
// the legal-opcode check, and the controller FSM state type.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_NOTA = 4'd7;
    localparam logic [3:0] OP_NOTB = 4'd8;
    localparam logic [3:0] OP_NAND = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd10;
    localparam logic [3:0] OP_XNOR = 4'd11;
    localparam logic [3:0] OP_XOR  = 4'd12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // Opcode 0 and 13..15 are not mapped to any ALU function.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/rr_arb.sv
// rr_arb: combinational round-robin picker.
//   req_i     - request vector (already masked by the caller)
//   rr_ptr_i  - index of the last winner; search starts at rr_ptr_i+1 with wrap
//   winner_o  - index of the chosen requester (0 when none)
//   any_req_o - high when at least one request is present
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  rr_ptr_i,
    output logic [IDW-1:0]  winner_o,
    output logic            any_req_o
);

    int unsigned       idx;
    logic [IDW-1:0]    idx_w;

    always_comb begin
        winner_o  = '0;
        any_req_o = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx   = (32'(rr_ptr_i) + k) % 32'(NREQ);
            idx_w = IDW'(idx);
            if (!any_req_o && req_i[idx_w]) begin
                winner_o  = idx_w;
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one external combinational 4-bit ALU between NREQ
// requesters using round-robin arbitration.
//   clk, rst        - clock, asynchronous active-high reset
//   req             - per-requester request, held until its ack cycle
//   op_in/a_in/b_in - per-requester opcode/operands, 4 bits each, packed by index
//   ack             - one-hot, high while that requester's op sits on the ALU
//   alu_a/alu_b/alu_s - registered ALU operands and opcode
//   alu_y           - ALU result
//   result, result_id, result_err, result_valid - tagged captured result
//   busy            - high while an op is executing
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] op_in,
    input  logic [4*NREQ-1:0] a_in,
    input  logic [4*NREQ-1:0] b_in,
    output logic [NREQ-1:0]   ack,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic [3:0]        alu_s,
    input  logic [3:0]        alu_y,
    output logic [3:0]        result,
    output logic [IDW-1:0]    result_id,
    output logic              result_err,
    output logic              result_valid,
    output logic              busy
);

    state_t          state_q, state_d;
    logic [IDW-1:0]  gnt_id_q, rr_ptr_q;
    logic [3:0]      alu_a_q, alu_b_q, alu_s_q;
    logic [3:0]      result_q;
    logic [IDW-1:0]  result_id_q;
    logic            result_err_q, result_valid_q;

    logic [NREQ-1:0] owner_mask, arb_req;
    logic [IDW-1:0]  winner;
    logic            any_req;
    logic [3:0]      win_op, win_a, win_b;

    // The requester currently on the ALU is excluded from re-arbitration so
    // its held req cannot win a second slot for the same operands.
    assign owner_mask = (state_q == ST_EXEC) ? (NREQ'(1) << gnt_id_q) : '0;
    assign arb_req    = req & ~owner_mask;

    rr_arb #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_arb (
        .req_i    (arb_req),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (winner),
        .any_req_o(any_req)
    );

    always_comb begin
        win_op = '0;
        win_a  = '0;
        win_b  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                win_op = op_in[4*i +: 4];
                win_a  = a_in[4*i +: 4];
                win_b  = b_in[4*i +: 4];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: both states issue whenever an eligible request exists
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = any_req ? ST_EXEC : ST_IDLE;
            ST_EXEC: state_d = any_req ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        ack  = '0;
        busy = 1'b0;
        if (state_q == ST_EXEC) begin
            ack[gnt_id_q] = 1'b1;
            busy          = 1'b1;
        end
    end

    // Grant, operand and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_id_q       <= '0;
            rr_ptr_q       <= IDW'(NREQ - 1);
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_s_q        <= '0;
            result_q       <= '0;
            result_id_q    <= '0;
            result_err_q   <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            if (any_req) begin
                gnt_id_q <= winner;
                rr_ptr_q <= winner;
                alu_s_q  <= win_op;
                alu_a_q  <= win_a;
                alu_b_q  <= win_b;
            end
            result_valid_q <= (state_q == ST_EXEC);
            if (state_q == ST_EXEC) begin
                result_q     <= alu_y;
                result_id_q  <= gnt_id_q;
                result_err_q <= !is_legal_op(alu_s_q) ||
                                ((alu_s_q == OP_DIV) && (alu_b_q == '0));
            end
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_s        = alu_s_q;
    assign result       = result_q;
    assign result_id    = result_id_q;
    assign result_err   = result_err_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

    localparam int N = 4;

    logic          clk, rst;
    logic [N-1:0]  req;
    logic [4*N-1:0] op_in, a_in, b_in;
    logic [N-1:0]  ack;
    logic [3:0]    alu_a, alu_b, alu_s, alu_y, result;
    logic [1:0]    result_id;
    logic          result_err, result_valid, busy;

    int checks = 0;
    int errors = 0;

    alu_share_ctrl #(.NREQ(N), .IDW(2)) dut (
        .clk(clk), .rst(rst), .req(req), .op_in(op_in), .a_in(a_in), .b_in(b_in),
        .ack(ack), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
        .result(result), .result_id(result_id), .result_err(result_err),
        .result_valid(result_valid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU standing in for the external instance.
    function automatic logic [3:0] alu_fn(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        case (s)
            4'd1:  return a + b;
            4'd2:  return a - b;
            4'd3:  return 4'((a * b) & 8'h0F);
            4'd4:  return (b == 4'd0) ? 4'hF : a / b;
            4'd5:  return a & b;
            4'd6:  return a | b;
            4'd7:  return ~a;
            4'd8:  return ~b;
            4'd9:  return ~(a & b);
            4'd10: return ~(a | b);
            4'd11: return ~(a ^ b);
            4'd12: return a ^ b;
            default: return 4'h0;
        endcase
    endfunction

    assign alu_y = alu_fn(alu_s, alu_a, alu_b);

    // Reference model: what is on the ALU, who owns it, and what was last retired.
    bit         m_exec;
    int         m_gnt, m_ptr;
    logic [3:0] m_s, m_a, m_b, m_res;
    bit         m_rv, m_rerr;
    int         m_rid;

    task automatic model_reset();
        m_exec = 0; m_gnt = 0; m_ptr = N - 1;
        m_s = 0; m_a = 0; m_b = 0;
        m_rv = 0; m_res = 0; m_rid = 0; m_rerr = 0;
    endtask

    function automatic logic [N-1:0] m_ack();
        logic [N-1:0] v;
        v = '0;
        if (m_exec) v[m_gnt] = 1'b1;
        return v;
    endfunction

    // Advance the model across one rising edge with the current inputs.
    task automatic model_step();
        int w;
        w = -1;
        m_rv = m_exec;
        if (m_exec) begin
            m_res  = alu_fn(m_s, m_a, m_b);
            m_rid  = m_gnt;
            m_rerr = (m_s == 0) || (m_s > 12) || (m_s == 4 && m_b == 0);
        end
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (w < 0 && req[idx] && !(m_exec && idx == m_gnt)) w = idx;
        end
        if (w >= 0) begin
            m_gnt = w; m_ptr = w;
            m_s = op_in[4*w +: 4]; m_a = a_in[4*w +: 4]; m_b = b_in[4*w +: 4];
            m_exec = 1;
        end else begin
            m_exec = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; op_in = '0; a_in = '0; b_in = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; op_in = '0; a_in = '0; b_in = '0;
        #1;
        checks++;
        if ({ack, alu_a, alu_b, alu_s, result, result_id, result_err, result_valid, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b a=%h b=%h s=%h res=%h id=%0d err=%b v=%b busy=%b exp all 0",
                     ack, alu_a, alu_b, alu_s, result, result_id, result_err, result_valid, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ack, busy, result_valid} !== '0) begin
            errors++;
            $display("FAIL reset_idle got ack=%b busy=%b v=%b exp 0", ack, busy, result_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        req = 4'b0001; op_in[3:0] = 4'd1; a_in[3:0] = 4'd5; b_in[3:0] = 4'd3;
        @(posedge clk); #1;
        checks++;
        if ({alu_s, alu_a, alu_b, ack, result_valid} !== {4'd1, 4'd5, 4'd3, 4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL single_issue got s=%h a=%h b=%h ack=%b v=%b exp 1 5 3 0001 0",
                     alu_s, alu_a, alu_b, ack, result_valid);
        end
        @(negedge clk); req = '0;
        @(posedge clk); #1;
        checks++;
        if ({ack, result_valid, result, result_id, result_err} !== {4'b0000, 1'b1, 4'd8, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL single_result got ack=%b v=%b res=%h id=%0d err=%b exp 0000 1 8 0 0",
                     ack, result_valid, result, result_id, result_err);
        end
        @(posedge clk); #1;
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse got v=%b exp 0", result_valid);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] exp_res [5] = '{4'd8, 4'd2, 4'd15, 4'd1, 4'd8};
        do_reset();
        @(negedge clk);
        req = 4'b1111; op_in = 16'h4321; a_in = 16'h5555; b_in = 16'h3333;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) begin @(negedge clk); req = '0; end
            @(posedge clk); #1;
            if (k < 5) begin
                checks++;
                if (ack !== exp_ack[k]) begin
                    errors++;
                    $display("FAIL rotation_ack%0d got %b exp %b", k, ack, exp_ack[k]);
                end
            end
            if (k > 0) begin
                checks++;
                if ({result_valid, result, result_id} !== {1'b1, exp_res[k-1], 2'((k-1) % 4)}) begin
                    errors++;
                    $display("FAIL rotation_res%0d got v=%b res=%h id=%0d exp 1 %h %0d",
                             k, result_valid, result, result_id, exp_res[k-1], (k-1) % 4);
                end
            end
        end
    endtask

    task automatic test_errors();
        logic [3:0] ops  [3] = '{4'd4, 4'd13, 4'd5};
        logic [3:0] bs   [3] = '{4'd0, 4'd3, 4'd3};
        logic [3:0] eres [3] = '{4'hF, 4'h0, 4'h1};
        logic       eerr [3] = '{1'b1, 1'b1, 1'b0};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req = 4'b0100; op_in[11:8] = ops[k]; a_in[11:8] = 4'd5; b_in[11:8] = bs[k];
            @(posedge clk); #1;
            checks++;
            if (ack !== 4'b0100) begin
                errors++;
                $display("FAIL err_ack%0d got %b exp 0100", k, ack);
            end
            @(negedge clk); req = '0;
            @(posedge clk); #1;
            checks++;
            if ({result_valid, result_id, result_err, result} !== {1'b1, 2'd2, eerr[k], eres[k]}) begin
                errors++;
                $display("FAIL err_result%0d got v=%b id=%0d err=%b res=%h exp 1 2 %b %h",
                         k, result_valid, result_id, result_err, result, eerr[k], eres[k]);
            end
        end
    endtask

    task automatic test_single_repeat();
        logic [3:0] a_cur, exp;
        do_reset();
        a_cur = 4'd1; exp = 4'd0;
        @(negedge clk);
        req = 4'b0010; op_in[7:4] = 4'd1; a_in[7:4] = a_cur; b_in[7:4] = 4'd1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (k % 2 == 0) begin
                checks++;
                if ({busy, ack, result_valid} !== {1'b1, 4'b0010, 1'b0}) begin
                    errors++;
                    $display("FAIL repeat_exec%0d got busy=%b ack=%b v=%b exp 1 0010 0", k, busy, ack, result_valid);
                end
                exp = a_cur + 4'd1;
                @(negedge clk);
                a_cur = a_cur + 4'd3; a_in[7:4] = a_cur;
            end else begin
                checks++;
                if ({busy, result_valid, result, result_id} !== {1'b0, 1'b1, exp, 2'd1}) begin
                    errors++;
                    $display("FAIL repeat_idle%0d got busy=%b v=%b res=%h id=%0d exp 0 1 %h 1",
                             k, busy, result_valid, result, result_id, exp);
                end
            end
        end
        @(negedge clk); req = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        req = 4'b1000; op_in[15:12] = 4'd6; a_in[15:12] = 4'd5; b_in[15:12] = 4'd3;
        @(posedge clk); #1;
        checks++;
        if (ack !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_ack got %b exp 1000", ack);
        end
        #2 rst = 1'b1; req = '0;
        #1;
        checks++;
        if ({ack, busy, alu_s, alu_a, alu_b} !== '0) begin
            errors++;
            $display("FAIL midrst_clear got ack=%b busy=%b s=%h a=%h b=%h exp 0", ack, busy, alu_s, alu_a, alu_b);
        end
        @(posedge clk); #1;
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_novalid got v=%b exp 0", result_valid);
        end
        @(negedge clk);
        rst = 1'b0; req = 4'b1001;
        op_in[3:0] = 4'd1; a_in[3:0] = 4'd1; b_in[3:0] = 4'd1;
        @(posedge clk); #1;
        checks++;
        if (ack !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_first got %b exp 0001", ack);
        end
        @(negedge clk); req = '0;
        @(posedge clk); #1;
        checks++;
        if ({result_valid, result_id} !== {1'b1, 2'd0}) begin
            errors++;
            $display("FAIL midrst_result got v=%b id=%0d exp 1 0", result_valid, result_id);
        end
    endtask

    task automatic test_operand_change();
        do_reset();
        @(negedge clk);
        req = 4'b0010; op_in[7:4] = 4'd1; a_in[7:4] = 4'd2; b_in[7:4] = 4'd3;
        @(posedge clk); #1;
        checks++;
        if (ack !== 4'b0010) begin
            errors++;
            $display("FAIL opchg_ack got %b exp 0010", ack);
        end
        a_in[7:4] = 4'd9;
        @(negedge clk); req = '0;
        @(posedge clk); #1;
        checks++;
        if ({result_valid, result, result_id} !== {1'b1, 4'd5, 2'd1}) begin
            errors++;
            $display("FAIL opchg_result got v=%b res=%h id=%0d exp 1 5 1", result_valid, result, result_id);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] ack_cur, ack_prev;
        do_reset();
        ack_cur = '0; ack_prev = '0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (ack_prev[i] || (!req[i] && ($urandom_range(2, 0) == 0))) begin
                    req[i] = ack_prev[i] ? 1'($urandom_range(1, 0)) : 1'b1;
                    op_in[4*i +: 4] = 4'($urandom_range(15, 0));
                    a_in[4*i +: 4]  = 4'($urandom_range(15, 0));
                    b_in[4*i +: 4]  = ($urandom_range(3, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 0));
                end
            end
            model_step();
            ack_prev = ack_cur;
            ack_cur  = m_ack();
            @(posedge clk); #1;
            checks++;
            if ({ack, busy, alu_s, alu_a, alu_b, result_valid} !==
                {m_ack(), 1'(m_exec), m_s, m_a, m_b, 1'(m_rv)}) begin
                errors++;
                $display("FAIL rand_issue%0d got ack=%b busy=%b s=%h a=%h b=%h v=%b exp %b %b %h %h %h %b",
                         n, ack, busy, alu_s, alu_a, alu_b, result_valid, m_ack(), m_exec, m_s, m_a, m_b, m_rv);
            end
            if (m_rv) begin
                checks++;
                if ({result, result_id, result_err} !== {m_res, 2'(m_rid), 1'(m_rerr)}) begin
                    errors++;
                    $display("FAIL rand_result%0d got res=%h id=%0d err=%b exp %h %0d %b",
                             n, result, result_id, result_err, m_res, m_rid, m_rerr);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; op_in = '0; a_in = '0; b_in = '0;
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_errors();
        test_single_repeat();
        test_reset_mid();
        test_operand_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
